// File: rtl/gem_tx_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gem_tx_seq_pkg
// Purpose  : State encoding, default parameters and timer sizing helper for
//            the GEM fiber TX bring-up sequencer.
// Revision : 1.0
// ============================================================================
package gem_tx_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_PLL_RST      = 4'd1,
        ST_PLL_WAIT     = 4'd2,
        ST_GTX_RST      = 4'd3,
        ST_RSTDONE_WAIT = 4'd4,
        ST_SYNC_WAIT    = 4'd5,
        ST_ALIGN        = 4'd6,
        ST_READY        = 4'd7,
        ST_FAIL         = 4'd8
    } state_e;

    localparam int DEF_RST_HOLD     = 16;
    localparam int DEF_LOCK_TIMEOUT = 4096;
    localparam int DEF_ALIGN_CYCLES = 256;
    localparam int DEF_MAX_RETRY    = 3;

    // Wide enough to hold the largest of the three load values.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gem_sync2.sv
`default_nettype none
// ============================================================================
// Module   : gem_sync2
// Purpose  : Two-flop synchronizer for a single asynchronous status bit.
// Revision : 1.0
// ============================================================================
module gem_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/gem_fiber_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gem_fiber_tx_sequencer
// Purpose  : PLL/GTX reset, phase-align and comma-window sequencer for the
//            GEM trigger fiber TX, with timeouts and bounded retries.
//            Optional READY lock monitor: define GEM_TX_SEQ_LOCKMON_EN.
// Revision : 1.0
// ============================================================================
module gem_fiber_tx_sequencer
    import gem_tx_seq_pkg::*;
#(
    parameter int RST_HOLD     = DEF_RST_HOLD,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int ALIGN_CYCLES = DEF_ALIGN_CYCLES,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic       TRG_CLK80,
    input  logic       RST_N,
    input  logic       START,
    input  logic       TRG_TX_PLL_LOCK,
    input  logic       TRG_TXRESETDONE,
    input  logic       TX_SYNC_DONE,
    output logic       TRG_TX_PLLRST,
    output logic       TRG_GTXTXRST,
    output logic       TRG_RST,
    output logic       LINK_READY,
    output logic       LINK_ERR,
    output logic [3:0] STATE,
    output logic [3:0] RETRY_CNT
);

    localparam int            TW        = tmr_width(RST_HOLD, LOCK_TIMEOUT, ALIGN_CYCLES);
    localparam logic [TW-1:0] HOLD_LD   = TW'(RST_HOLD - 1);
    localparam logic [TW-1:0] WAIT_LD   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] ALIGN_LD  = TW'(ALIGN_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

    logic lock_s;
    logic rdone_s;
    logic sync_s;

    gem_sync2 u_sync_lock  (.clk(TRG_CLK80), .rst_n(RST_N), .d(TRG_TX_PLL_LOCK), .q(lock_s));
    gem_sync2 u_sync_rdone (.clk(TRG_CLK80), .rst_n(RST_N), .d(TRG_TXRESETDONE), .q(rdone_s));
    gem_sync2 u_sync_sdone (.clk(TRG_CLK80), .rst_n(RST_N), .d(TX_SYNC_DONE),    .q(sync_s));

    state_e        state_q,  state_d;
    logic [TW-1:0] tmr_q,    tmr_d;
    logic [3:0]    retry_q,  retry_d;
    logic          pllrst_q, pllrst_d;
    logic          gtxrst_q, gtxrst_d;
    logic          trgrst_q, trgrst_d;
    logic          ready_q,  ready_d;
    logic          err_q,    err_d;
    logic          fault;
    logic [3:0]    retry_inc;

`ifdef GEM_TX_SEQ_LOCKMON_EN
    logic          lock_lo_q, lock_lo_d;
    assign lock_lo_d = (state_q == ST_READY) && !lock_s;
`endif

    assign retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        tmr_d   = tmr_q;
        fault   = 1'b0;

        if (!START) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PLL_RST;
                    retry_d = 4'd0;
                end
                ST_PLL_RST:
                    if (tmr_q == '0) state_d = ST_PLL_WAIT;
                ST_PLL_WAIT:
                    if (lock_s)              state_d = ST_GTX_RST;
                    else if (tmr_q == '0)    fault   = 1'b1;
                ST_GTX_RST:
                    if (tmr_q == '0) state_d = ST_RSTDONE_WAIT;
                // Lock loss outranks progress; a status edge outranks the timeout.
                ST_RSTDONE_WAIT:
                    if (!lock_s)             fault   = 1'b1;
                    else if (rdone_s)        state_d = ST_SYNC_WAIT;
                    else if (tmr_q == '0)    fault   = 1'b1;
                ST_SYNC_WAIT:
                    if (!lock_s)             fault   = 1'b1;
                    else if (sync_s)         state_d = ST_ALIGN;
                    else if (tmr_q == '0)    fault   = 1'b1;
                ST_ALIGN:
                    if (!lock_s)             fault   = 1'b1;
                    else if (tmr_q == '0)    state_d = ST_READY;
                ST_READY: begin
`ifdef GEM_TX_SEQ_LOCKMON_EN
                    if (!lock_s && lock_lo_q) fault = 1'b1;
`endif
                end
                ST_FAIL: ;
                default: state_d = ST_IDLE;
            endcase

            if (fault) begin
                retry_d = retry_inc;
                state_d = (retry_inc >= RETRY_LIM) ? ST_FAIL : ST_PLL_RST;
            end
        end

        if (state_d != state_q) begin
            case (state_d)
                ST_PLL_RST, ST_GTX_RST:                       tmr_d = HOLD_LD;
                ST_PLL_WAIT, ST_RSTDONE_WAIT, ST_SYNC_WAIT:   tmr_d = WAIT_LD;
                ST_ALIGN:                                     tmr_d = ALIGN_LD;
                default:                                      tmr_d = '0;
            endcase
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_ONE;
        end

        // Outputs follow the next state so they flip on the same edge as STATE.
        pllrst_d = (state_d == ST_IDLE) || (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
        gtxrst_d = (state_d == ST_IDLE) || (state_d == ST_PLL_RST) || (state_d == ST_PLL_WAIT) ||
                   (state_d == ST_GTX_RST) || (state_d == ST_FAIL);
        trgrst_d = (state_d != ST_READY);
        ready_d  = (state_d == ST_READY);
        err_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge TRG_CLK80 or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            retry_q   <= 4'd0;
            pllrst_q  <= 1'b1;
            gtxrst_q  <= 1'b1;
            trgrst_q  <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef GEM_TX_SEQ_LOCKMON_EN
            lock_lo_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            retry_q   <= retry_d;
            pllrst_q  <= pllrst_d;
            gtxrst_q  <= gtxrst_d;
            trgrst_q  <= trgrst_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
`ifdef GEM_TX_SEQ_LOCKMON_EN
            lock_lo_q <= lock_lo_d;
`endif
        end
    end

    assign TRG_TX_PLLRST = pllrst_q;
    assign TRG_GTXTXRST  = gtxrst_q;
    assign TRG_RST       = trgrst_q;
    assign LINK_READY    = ready_q;
    assign LINK_ERR      = err_q;
    assign STATE         = state_q;
    assign RETRY_CNT     = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_gem_fiber_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gem_fiber_tx_sequencer
// Purpose  : Scenario-driven random bench with a cycle-level reference model
//            and queue scoreboard for gem_fiber_tx_sequencer.
// Revision : 1.0
// ============================================================================
module tb_gem_fiber_tx_sequencer;

    localparam int RST_HOLD     = 4;
    localparam int LOCK_TIMEOUT = 16;
    localparam int ALIGN_CYCLES = 8;
    localparam int MAX_RETRY    = 2;
    localparam int NEVER        = 1000000;

    localparam int P_IDLE = 0, P_PLL_RST = 1, P_PLL_WAIT = 2, P_GTX_RST = 3, P_RDONE = 4,
                   P_SYNC = 5, P_ALIGN = 6, P_READY = 7, P_FAIL = 8;

    localparam logic [12:0] RESET_VEC = 13'b0000_0000_11100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       lock = 1'b0;
    logic       rdone = 1'b0;
    logic       sdone = 1'b0;
    logic       pllrst, gtxrst, trgrst, ready, err;
    logic [3:0] state, retry;
    logic [12:0] act;

    always #5 clk = ~clk;

    gem_fiber_tx_sequencer #(
        .RST_HOLD    (RST_HOLD),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .ALIGN_CYCLES(ALIGN_CYCLES),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .TRG_CLK80      (clk),
        .RST_N          (rst_n),
        .START          (start),
        .TRG_TX_PLL_LOCK(lock),
        .TRG_TXRESETDONE(rdone),
        .TX_SYNC_DONE   (sdone),
        .TRG_TX_PLLRST  (pllrst),
        .TRG_GTXTXRST   (gtxrst),
        .TRG_RST        (trgrst),
        .LINK_READY     (ready),
        .LINK_ERR       (err),
        .STATE          (state),
        .RETRY_CNT      (retry)
    );

    assign act = {state, retry, pllrst, gtxrst, trgrst, ready, err};

    typedef struct {
        logic [12:0] v;
        int          scen;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;

    // Reference model: phase, cycles shown in that phase, retry count,
    // and the last two raw input samples (what the synchronizers hold).
    int ph = 0, el = 0, rc = 0;
    bit l1, l2, r1, r2, s1, s2;
`ifdef GEM_TX_SEQ_LOCKMON_EN
    int lowrun = 0;
`endif

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got state=%0d retry=%0d pll/gtx/trg/rdy/err=%b, expected state=%0d retry=%0d pll/gtx/trg/rdy/err=%b",
                     name, got[12:9], got[8:5], got[4:0], want[12:9], want[8:5], want[4:0]);
        end
    endtask

    function automatic logic [12:0] model_vec();
        logic p, g, t, r, e;
        p = (ph == P_IDLE) || (ph == P_FAIL) || (ph == P_PLL_RST);
        g = (ph == P_IDLE) || (ph == P_FAIL) || (ph >= P_PLL_RST && ph <= P_GTX_RST);
        t = (ph != P_READY);
        r = (ph == P_READY);
        e = (ph == P_FAIL);
        return {4'(ph), 4'(rc), p, g, t, r, e};
    endfunction

    task automatic model_reset();
        ph = P_IDLE; el = 0; rc = 0;
        l1 = 0; l2 = 0; r1 = 0; r2 = 0; s1 = 0; s2 = 0;
`ifdef GEM_TX_SEQ_LOCKMON_EN
        lowrun = 0;
`endif
    endtask

    task automatic model_edge(input bit st, input bit lk, input bit rd, input bit sd);
        int nxt;
        bit fault;
        nxt = ph;
        fault = 0;
        if (!st) begin
            nxt = P_IDLE;
        end else begin
            case (ph)
                P_IDLE:     begin nxt = P_PLL_RST; rc = 0; end
                P_PLL_RST:  if (el >= RST_HOLD) nxt = P_PLL_WAIT;
                P_PLL_WAIT: if (l2) nxt = P_GTX_RST; else if (el >= LOCK_TIMEOUT) fault = 1;
                P_GTX_RST:  if (el >= RST_HOLD) nxt = P_RDONE;
                P_RDONE:    if (!l2) fault = 1; else if (r2) nxt = P_SYNC;  else if (el >= LOCK_TIMEOUT) fault = 1;
                P_SYNC:     if (!l2) fault = 1; else if (s2) nxt = P_ALIGN; else if (el >= LOCK_TIMEOUT) fault = 1;
                P_ALIGN:    if (!l2) fault = 1; else if (el >= ALIGN_CYCLES) nxt = P_READY;
                P_READY: begin
`ifdef GEM_TX_SEQ_LOCKMON_EN
                    lowrun = l2 ? 0 : lowrun + 1;
                    if (lowrun >= 2) fault = 1;
`endif
                end
                default: ;
            endcase
            if (fault) begin
                rc  = (rc < 15) ? rc + 1 : 15;
                nxt = (rc >= MAX_RETRY) ? P_FAIL : P_PLL_RST;
            end
        end
        if (nxt != ph) begin
            el = 1;
`ifdef GEM_TX_SEQ_LOCKMON_EN
            lowrun = 0;
`endif
        end else begin
            el++;
        end
        ph = nxt;
        l2 = l1; l1 = lk;
        r2 = r1; r1 = rd;
        s2 = s1; s1 = sd;
    endtask

    task automatic push_exp(input int id, input int c);
        exp_t e;
        e.v = model_vec();
        e.scen = id;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // One bring-up episode; all event times are cycles after START rises.
    task automatic run_scen(input int id, input int t_lock, input int t_rd, input int t_sd,
                            input int t_drop, input int drop_len, input int t_sl, input int sl_len,
                            input int t_rst, input int len);
        for (int c = -3; c < len; c++) begin
            bit st, lk;
            @(negedge clk);
            st = (c >= 0) && !(c >= t_sl && c < t_sl + sl_len);
            lk = (c >= t_lock) && !(c >= t_drop && c < t_drop + drop_len);
            start = st;
            lock  = lk;
            rdone = (c >= t_rd);
            sdone = (c >= t_sd);
            if (c >= t_rst && c < t_rst + 2) begin
                if (rst_n) begin
                    rst_n = 1'b0;
                    #1;
                    check($sformatf("async_rst_scen%0d_cyc%0d", id, c), act, RESET_VEC);
                end
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
                model_edge(st, lk, rdone, sdone);
            end
            push_exp(id, c);
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_exp(-1, i);
        end
        // id, lock, rdone, sync, drop, droplen, startlow, sl_len, rst, len
        run_scen(0, 10, 20, 30, NEVER, 0, NEVER, 0, NEVER, 60);        // nominal
        run_scen(1, NEVER, NEVER, NEVER, NEVER, 0, NEVER, 0, NEVER, 60); // lock never -> FAIL
        run_scen(2, 10, 20, NEVER, 25, 4, NEVER, 0, NEVER, 100);        // lock drop in SYNC_WAIT
        run_scen(3, 10, 20, 30, 13, 1, 35, 3, NEVER, 90);               // START low in ALIGN
        run_scen(4, 10, 20, 30, NEVER, 0, NEVER, 0, 50, 100);           // RST_N in READY
        run_scen(5, 10, 20, 30, 50, 2, NEVER, 0, NEVER, 80);            // lock low 2 cycles in READY
        run_scen(6, 10, 20, 30, 50, 1, NEVER, 0, NEVER, 80);            // lock low 1 cycle in READY
        run_scen(7, 18, 30, 40, NEVER, 0, NEVER, 0, NEVER, 80);         // lock on the timeout cycle
        run_scen(8, 19, 30, 40, NEVER, 0, NEVER, 0, NEVER, 100);        // lock one cycle too late
        for (int s = 0; s < 40; s++) begin
            int tl, tr, ts, td, dl, tsl, sll, trs;
            tl  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 30));
            tr  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(5, 50));
            ts  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(10, 70));
            td  = NEVER; dl = 0; tsl = NEVER; sll = 0; trs = NEVER;
            if ($urandom_range(0, 2) == 0) begin
                td = int'($urandom_range(10, 90));
                dl = int'($urandom_range(1, 8));
            end
            if ($urandom_range(0, 3) == 0) begin
                tsl = int'($urandom_range(5, 90));
                sll = int'($urandom_range(1, 4));
            end
            if ($urandom_range(0, 5) == 0) trs = int'($urandom_range(5, 90));
            run_scen(100 + s, tl, tr, ts, td, dl, tsl, sll, trs, 130);
        end
        stim_done = 1'b1;
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("scen%0d_cyc%0d", e.scen, e.cyc), act, e.v);
            end else if (stim_done) begin
                break;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gem_fiber_tx_sequencer.md
# gem_fiber_tx_sequencer

Bring-up and recovery controller for the GEM trigger fiber transmitter; it runs in the TRG_CLK80 domain.
- Sequences the TX PLL reset, GTX TX reset and TX phase-alignment completion, then holds the data reset (comma pattern) for a fixed alignment window before releasing payload.
- Applies per-stage timeouts and bounded retries, and reports link status to slow control.
- Sits between slow control / top-level reset and the fiber output block's TRG_TX_PLLRST, TRG_GTXTXRST and TRG_RST inputs.

## Interface
Parameters:
- RST_HOLD, 16: cycles TRG_TX_PLLRST and TRG_GTXTXRST pulses are held high
- LOCK_TIMEOUT, 4096: max cycles to wait for each status input (lock, reset done, sync done)
- ALIGN_CYCLES, 256: cycles TRG_RST held high after sync done, before data release
- MAX_RETRY, 3: timeouts tolerated before FAIL (1..15)

Ports:
- TRG_CLK80  in  1  80 MHz fabric clock, sole clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  level; high requests link bring-up, low forces IDLE
- TRG_TX_PLL_LOCK  in  1  async; GTX TX PLL lock
- TRG_TXRESETDONE  in  1  async; GTX TX reset done
- TX_SYNC_DONE  in  1  async; TX phase alignment done
- TRG_TX_PLLRST  out  1  PLL reset to transceiver
- TRG_GTXTXRST  out  1  GTX TX reset
- TRG_RST  out  1  data reset (comma/idle pattern while high)
- LINK_READY  out  1  high only in READY
- LINK_ERR  out  1  high only in FAIL
- STATE  out  4  current state encoding
- RETRY_CNT  out  4  timeouts since last START rise

## Operation
- Status inputs pass through 2-flop synchronizers; all decisions use synchronized values.
- One down-counter `tmr` (width clog2 of max(RST_HOLD, LOCK_TIMEOUT, ALIGN_CYCLES)+1) is loaded on every state entry.
- States and encodings:
  - IDLE=0: all resets high. START -> PLL_RST, RETRY_CNT cleared.
  - PLL_RST=1: PLLRST=1, GTXTXRST=1, TRG_RST=1 for RST_HOLD cycles -> PLL_WAIT.
  - PLL_WAIT=2: PLLRST=0. lock -> GTX_RST.
  - GTX_RST=3: GTXTXRST=1 for RST_HOLD cycles -> RSTDONE_WAIT.
  - RSTDONE_WAIT=4: GTXTXRST=0. resetdone -> SYNC_WAIT.
  - SYNC_WAIT=5: sync done -> ALIGN.
  - ALIGN=6: TRG_RST=1 for ALIGN_CYCLES cycles -> READY.
  - READY=7: TRG_RST=0, LINK_READY=1.
  - FAIL=8: all resets high, LINK_ERR=1. Stays until START low, then -> IDLE.
- Timeout: `tmr` reaching 0 in any wait state (PLL_WAIT, RSTDONE_WAIT, SYNC_WAIT) increments RETRY_CNT.
  - If the incremented count is below MAX_RETRY -> PLL_RST.
  - If it equals MAX_RETRY -> FAIL.
- RETRY_CNT saturates at 15.
- Loss of lock while in RSTDONE_WAIT, SYNC_WAIT or ALIGN -> PLL_RST with RETRY_CNT +1, same FAIL rule as a timeout.
- START low in any state -> IDLE next cycle; this has priority over all other transitions.
- TRG_RST is high in every state except READY.

## Timing
- Reset values (RST_N low, asynchronous):
  - STATE=IDLE, RETRY_CNT=0
  - TRG_TX_PLLRST=1, TRG_GTXTXRST=1, TRG_RST=1
  - LINK_READY=0, LINK_ERR=0
  - synchronizers cleared
- All outputs are registered and reflect STATE the same cycle STATE is visible.
- START rise in IDLE: STATE=PLL_RST on the next edge; PLLRST stays high exactly RST_HOLD cycles in PLL_RST.
- Input-to-transition latency: 2 synchronizer cycles + 1 state register cycle = 3 cycles.
- Equal-cycle events:
  - Status input arrives on the same cycle as timeout: the status input wins.
  - START low coincides with any other event: START low wins.
- RST_N deasserted mid-sequence: bring-up restarts from IDLE; no state is retained.

## Configuration
- GEM_TX_SEQ_LOCKMON_EN
  - Defined: in READY, synchronized lock low for 2 consecutive cycles -> PLL_RST, RETRY_CNT +1 (FAIL rule applies).
  - Undefined: lock is ignored in READY; READY is left only via START low or RST_N.

## Structure
- Package gem_tx_seq_pkg holds:
  - the state enum (4-bit, encodings above)
  - the default parameter constants
  - a clog2-based timer width function
- One sub-module, gem_sync2: a 2-flop synchronizer with active-low async reset, instantiated three times.

## Test plan
All scenarios use RST_HOLD=4, LOCK_TIMEOUT=16, ALIGN_CYCLES=8, MAX_RETRY=2.
- Nominal bring-up: START=1, lock at +10, resetdone at +20, syncdone at +30 -> PLLRST high exactly 4 cycles; READY reached 8 cycles after SYNC_WAIT exits; TRG_RST falls with LINK_READY rise.
- Lock never asserts -> timeout after 16 cycles in PLL_WAIT, RETRY_CNT=1, re-enter PLL_RST; second timeout -> FAIL, LINK_ERR=1, RETRY_CNT=2.
- Lock drops in SYNC_WAIT -> PLL_RST within 3 cycles, RETRY_CNT=1.
- START low in ALIGN -> IDLE next edge, all resets high; START high again -> RETRY_CNT=0.
- RST_N pulsed low in READY -> immediate reset values on all outputs, without waiting for a clock edge.
- With the macro: lock low 2 cycles in READY -> PLL_RST. Without: stays READY.
